// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared command/response codes and scheduler state encoding
package sensor_pkg;

    localparam logic [7:0] CMD_PING   = 8'h00;
    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_CONT_A = 8'h03;
    localparam logic [7:0] CMD_CONT_B = 8'h04;
    localparam logic [7:0] CMD_STOP_A = 8'h05;
    localparam logic [7:0] CMD_STOP_B = 8'h06;
    localparam logic [7:0] CMD_LAST   = CMD_STOP_B;

    localparam logic [7:0] RSP_STOP_ACK   = 8'h0A;
    localparam logic [7:0] RSP_SENSOR_ERR = 8'h1F;
    localparam logic [7:0] RSP_BAD_ADDR   = 8'hDF;
    localparam logic [7:0] RSP_BAD_CMD    = 8'hEF;
    localparam logic [7:0] RSP_PAD        = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_CHECK        = 3'd1,
        ST_ISSUE        = 3'd2,
        ST_WAIT_SENSOR  = 3'd3,
        ST_LOAD_TX      = 3'd4,
        ST_WAIT_TX_ACK  = 3'd5,
        ST_WAIT_TX_DONE = 3'd6
    } state_t;

    function automatic logic is_known_cmd(input logic [7:0] cmd);
        return cmd <= CMD_LAST;
    endfunction

    function automatic logic is_cont_cmd(input logic [7:0] cmd);
        return (cmd == CMD_CONT_A) || (cmd == CMD_CONT_B);
    endfunction

    function automatic logic is_stop_cmd(input logic [7:0] cmd);
        return (cmd == CMD_STOP_A) || (cmd == CMD_STOP_B);
    endfunction

endpackage

// File: rtl/command_scheduler_if.sv
// rtl/command_scheduler_if.sv - host, sensor and transmitter handshake bundle
interface command_scheduler_if;

    logic       rx_done;
    logic [7:0] rx_command;
    logic [7:0] rx_address;

    logic       sensor_start;
    logic [7:0] sensor_command;
    logic [7:0] sensor_address;
    logic       sensor_done;
    logic [7:0] sensor_resp_command;
    logic [7:0] sensor_resp_value;
    logic       sensor_error;

    logic       tx_start;
    logic [7:0] tx_command;
    logic [7:0] tx_value;
    logic       tx_busy;

    logic       busy;
    logic       overflow;

    // scheduler side
    modport master (
        input  rx_done, rx_command, rx_address,
        input  sensor_done, sensor_resp_command, sensor_resp_value, sensor_error,
        input  tx_busy,
        output sensor_start, sensor_command, sensor_address,
        output tx_start, tx_command, tx_value,
        output busy, overflow
    );

    // environment side (host receiver, sensor engine, transmitter)
    modport slave (
        output rx_done, rx_command, rx_address,
        output sensor_done, sensor_resp_command, sensor_resp_value, sensor_error,
        output tx_busy,
        input  sensor_start, sensor_command, sensor_address,
        input  tx_start, tx_command, tx_value,
        input  busy, overflow
    );

endinterface

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - wrapping cycle counter with enable, clear and terminal count
module cycle_timer #(
    parameter int unsigned LIMIT = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic terminal
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    assign terminal = enable && (count == LAST);

    // count while enabled, wrap to zero on the terminal cycle; clear wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/command_scheduler.sv
// rtl/command_scheduler.sv - host request scheduler for sensor transactions and UART replies
module command_scheduler
    import sensor_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned POLL_CYCLES    = 100_000_000,
    parameter int unsigned MAX_ADDRESS    = 31
) (
    input  logic                clock,
    input  logic                reset,
    command_scheduler_if.master bus
);

    localparam logic [7:0] MAX_ADDR8 = 8'(MAX_ADDRESS);

    state_t     state;
    state_t     state_next;

    logic       pend_valid;
    logic [7:0] pend_cmd;
    logic [7:0] pend_addr;
    logic       overflow;

    logic       slot_valid;
    logic [7:0] slot_cmd;
    logic [7:0] slot_addr;
    logic       poll_due;

    logic [7:0] req_cmd;
    logic [7:0] req_addr;
    logic       req_is_poll;

    logic [7:0] sensor_command;
    logic [7:0] sensor_address;
    logic [7:0] tx_command;
    logic [7:0] tx_value;
    logic       sensor_start;
    logic       tx_start;
    logic       busy;

    logic       poll_tc;
    logic       timeout_tc;

    // A host request waiting in the pending register always beats a poll.
    // While rx_done is high the request is not yet in the register, so the
    // poll is held back one cycle to let the host request land first.
    logic take_pending;
    logic take_poll;
    assign take_pending = (state == ST_IDLE) && pend_valid;
    assign take_poll    = (state == ST_IDLE) && !pend_valid && !bus.rx_done
                          && poll_due && slot_valid;

    logic chk_bad_addr;
    logic chk_bad_cmd;
    logic chk_stop;
    logic chk_reject;
    logic slot_load;
    logic slot_clear;
    assign chk_bad_addr = req_addr > MAX_ADDR8;
    assign chk_bad_cmd  = !is_known_cmd(req_cmd);
    assign chk_stop     = is_stop_cmd(req_cmd);
    assign chk_reject   = chk_bad_addr || chk_bad_cmd;
    assign slot_clear   = (state == ST_CHECK) && !chk_reject && chk_stop;
    // poll requests come from the slot itself, so they never reload it
    assign slot_load    = (state == ST_CHECK) && !chk_reject
                          && is_cont_cmd(req_cmd) && !req_is_poll;

    cycle_timer #(.LIMIT(POLL_CYCLES)) u_poll_timer (
        .clock    (clock),
        .reset    (reset),
        .enable   (slot_valid),
        .clear    (slot_load || slot_clear),
        .terminal (poll_tc)
    );

    cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_timer (
        .clock    (clock),
        .reset    (reset),
        .enable   (state == ST_WAIT_SENSOR),
        .clear    (state == ST_ISSUE),
        .terminal (timeout_tc)
    );

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:         if (take_pending || take_poll) state_next = ST_CHECK;
            ST_CHECK:        state_next = (chk_reject || chk_stop) ? ST_LOAD_TX : ST_ISSUE;
            ST_ISSUE:        state_next = ST_WAIT_SENSOR;
            ST_WAIT_SENSOR:  if (bus.sensor_done || timeout_tc) state_next = ST_LOAD_TX;
            ST_LOAD_TX:      if (!bus.tx_busy) state_next = ST_WAIT_TX_ACK;
            ST_WAIT_TX_ACK:  if (bus.tx_busy) state_next = ST_WAIT_TX_DONE;
            ST_WAIT_TX_DONE: if (!bus.tx_busy) state_next = ST_IDLE;
            default:         state_next = ST_IDLE;
        endcase
    end

    // strobes and status decoded from the current state
    always_comb begin
        sensor_start = (state == ST_ISSUE);
        tx_start     = (state == ST_LOAD_TX) && !bus.tx_busy;
        busy         = (state != ST_IDLE);
    end

    // one-deep pending register and sticky overflow; the IDLE hand-off frees
    // the slot in the same cycle, so a request arriving then is still kept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_cmd   <= '0;
            pend_addr  <= '0;
            overflow   <= 1'b0;
        end else if (bus.rx_done) begin
            if (pend_valid && !take_pending) begin
                overflow <= 1'b1;
            end else begin
                pend_valid <= 1'b1;
                pend_cmd   <= bus.rx_command;
                pend_addr  <= bus.rx_address;
            end
        end else if (take_pending) begin
            pend_valid <= 1'b0;
        end
    end

    // request under service, continuous slot and poll scheduling
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_cmd     <= '0;
            req_addr    <= '0;
            req_is_poll <= 1'b0;
            slot_valid  <= 1'b0;
            slot_cmd    <= '0;
            slot_addr   <= '0;
            poll_due    <= 1'b0;
        end else begin
            if (take_pending) begin
                req_cmd     <= pend_cmd;
                req_addr    <= pend_addr;
                req_is_poll <= 1'b0;
            end else if (take_poll) begin
                req_cmd     <= slot_cmd;
                req_addr    <= slot_addr;
                req_is_poll <= 1'b1;
            end

            if (slot_clear) begin
                slot_valid <= 1'b0;
                slot_cmd   <= '0;
                slot_addr  <= '0;
            end else if (slot_load) begin
                slot_valid <= 1'b1;
                slot_cmd   <= req_cmd;
                slot_addr  <= req_addr;
            end

            if (slot_clear || slot_load) begin
                poll_due <= 1'b0;
            end else if (poll_tc) begin
                poll_due <= 1'b1;
            end else if (take_poll) begin
                poll_due <= 1'b0;
            end
        end
    end

    // sensor request and reply bytes; the reply is only rewritten while the
    // transmitter is idle, so it stays put for the whole transmission
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sensor_command <= '0;
            sensor_address <= '0;
            tx_command     <= '0;
            tx_value       <= '0;
        end else if (state == ST_CHECK) begin
            if (chk_bad_addr) begin
                tx_command <= RSP_BAD_ADDR;
                tx_value   <= RSP_PAD;
            end else if (chk_bad_cmd) begin
                tx_command <= RSP_BAD_CMD;
                tx_value   <= RSP_PAD;
            end else if (chk_stop) begin
                tx_command <= RSP_STOP_ACK;
                tx_value   <= RSP_PAD;
            end else begin
                sensor_command <= req_cmd;
                sensor_address <= req_addr;
            end
        end else if (state == ST_WAIT_SENSOR) begin
            if (bus.sensor_done) begin
                tx_command <= bus.sensor_error ? RSP_SENSOR_ERR : bus.sensor_resp_command;
                tx_value   <= bus.sensor_error ? RSP_PAD : bus.sensor_resp_value;
            end else if (timeout_tc) begin
                tx_command <= RSP_SENSOR_ERR;
                tx_value   <= RSP_PAD;
            end
        end
    end

    assign bus.sensor_start   = sensor_start;
    assign bus.sensor_command = sensor_command;
    assign bus.sensor_address = sensor_address;
    assign bus.tx_start       = tx_start;
    assign bus.tx_command     = tx_command;
    assign bus.tx_value       = tx_value;
    assign bus.busy           = busy;
    assign bus.overflow       = overflow;

endmodule

// File: tb/tb_command_scheduler.sv
// tb/tb_command_scheduler.sv - directed vector bench for command_scheduler
module tb_command_scheduler;

    logic clock;
    logic reset;
    command_scheduler_if bus ();

    command_scheduler #(
        .TIMEOUT_CYCLES (100),
        .POLL_CYCLES    (1000),
        .MAX_ADDRESS    (31)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] addr;
        int         delay;
        logic [7:0] rc;
        logic [7:0] rv;
        logic       err;
        int         exp_starts;
        logic [7:0] exp_tc;
        logic [7:0] exp_tv;
        int         lat_min;
        int         lat_max;
    } vec_t;

    vec_t vecs [9];

    int checks;
    int failures;

    int cyc;
    int done_at;
    int busy_left;
    int n_start;
    int n_tx;
    int start_cyc;
    int tx_cyc;
    int sens_delay;
    logic [7:0] sens_rc;
    logic [7:0] sens_rv;
    logic       sens_err;
    logic [7:0] st_cmd;
    logic [7:0] st_addr;
    logic [7:0] tx_c;
    logic [7:0] tx_v;
    int         start_log [$];
    logic [7:0] addr_log [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, val, lo, hi);
        end
    endtask

    function automatic logic [35:0] all_outputs();
        return {bus.sensor_start, bus.sensor_command, bus.sensor_address,
                bus.tx_start, bus.tx_command, bus.tx_value, bus.busy, bus.overflow};
    endfunction

    // one cycle of the sensor and transmitter models, called at a falling edge
    task automatic env_step();
        logic s_start;
        logic s_tx;
        s_start = bus.sensor_start;
        s_tx    = bus.tx_start;
        if (s_start) begin
            n_start++;
            start_cyc = cyc;
            done_at   = cyc + sens_delay;
            st_cmd    = bus.sensor_command;
            st_addr   = bus.sensor_address;
            start_log.push_back(cyc);
            addr_log.push_back(bus.sensor_address);
        end
        if (s_tx) begin
            n_tx++;
            tx_cyc = cyc;
            tx_c   = bus.tx_command;
            tx_v   = bus.tx_value;
        end
        bus.sensor_done         = (cyc == done_at);
        bus.sensor_resp_command = sens_rc;
        bus.sensor_resp_value   = sens_rv;
        bus.sensor_error        = sens_err;
        bus.tx_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (s_tx) busy_left = 4;
        @(negedge clock);
        cyc++;
        bus.rx_done = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) env_step();
    endtask

    task automatic send_rx(input logic [7:0] c, input logic [7:0] a);
        bus.rx_command = c;
        bus.rx_address = a;
        bus.rx_done    = 1'b1;
        env_step();
    endtask

    task automatic clear_stats();
        n_start = 0;
        n_tx    = 0;
        done_at = -1;
        tx_c    = 8'h00;
        tx_v    = 8'h00;
        start_log.delete();
        addr_log.delete();
    endtask

    task automatic wait_starts(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (n_start < n && k < budget) begin
            env_step();
            k++;
        end
        check_range(name, n_start, n, n);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        check(name, 64'(all_outputs()), 64'd0);
        busy_left        = 0;
        done_at          = -1;
        bus.tx_busy      = 1'b0;
        bus.sensor_done  = 1'b0;
        bus.rx_done      = 1'b0;
        @(negedge clock);
        cyc++;
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        busy_left = 0;
        sens_delay = 1;
        sens_rc  = 8'h00;
        sens_rv  = 8'h00;
        sens_err = 1'b0;
        clear_stats();
        bus.rx_done = 1'b0;
        bus.rx_command = 8'h00;
        bus.rx_address = 8'h00;
        bus.sensor_done = 1'b0;
        bus.sensor_resp_command = 8'h00;
        bus.sensor_resp_value = 8'h00;
        bus.sensor_error = 1'b0;
        bus.tx_busy = 1'b0;

        //            cmd    addr   dly  rc     rv     err   st  exp_tc exp_tv lat
        vecs[0] = '{8'h01, 8'h01,  50, 8'h09, 8'h19, 1'b0, 1, 8'h09, 8'h19,  51,  54};
        vecs[1] = '{8'h01, 8'h40,   1, 8'h00, 8'h00, 1'b0, 0, 8'hDF, 8'h00,   0,   0};
        vecs[2] = '{8'h77, 8'h01,   1, 8'h00, 8'h00, 1'b0, 0, 8'hEF, 8'h00,   0,   0};
        vecs[3] = '{8'h02, 8'h03, 120, 8'h11, 8'h22, 1'b0, 1, 8'h1F, 8'h00, 100, 104};
        vecs[4] = '{8'h00, 8'h1F,   3, 8'h55, 8'h66, 1'b1, 1, 8'h1F, 8'h00,   4,   7};
        vecs[5] = '{8'h01, 8'h1F,   1, 8'h31, 8'h7E, 1'b0, 1, 8'h31, 8'h7E,   2,   5};
        vecs[6] = '{8'h00, 8'h20,   1, 8'h00, 8'h00, 1'b0, 0, 8'hDF, 8'h00,   0,   0};
        vecs[7] = '{8'h07, 8'h00,   1, 8'h00, 8'h00, 1'b0, 0, 8'hEF, 8'h00,   0,   0};
        vecs[8] = '{8'h06, 8'h05,   1, 8'h00, 8'h00, 1'b0, 0, 8'h0A, 8'h00,   0,   0};

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_outputs", 64'(all_outputs()), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            clear_stats();
            sens_delay = vecs[i].delay;
            sens_rc    = vecs[i].rc;
            sens_rv    = vecs[i].rv;
            sens_err   = vecs[i].err;
            send_rx(vecs[i].cmd, vecs[i].addr);
            run(200);
            check($sformatf("vec%0d_starts", i), 64'(n_start), 64'(vecs[i].exp_starts));
            check($sformatf("vec%0d_tx_count", i), 64'(n_tx), 64'd1);
            check($sformatf("vec%0d_tx_bytes", i), 64'({tx_c, tx_v}),
                  64'({vecs[i].exp_tc, vecs[i].exp_tv}));
            if (vecs[i].exp_starts > 0) begin
                check($sformatf("vec%0d_sensor_req", i), 64'({st_cmd, st_addr}),
                      64'({vecs[i].cmd, vecs[i].addr}));
                check_range($sformatf("vec%0d_latency", i), tx_cyc - start_cyc,
                            vecs[i].lat_min, vecs[i].lat_max);
            end
            check($sformatf("vec%0d_busy_end", i), 64'(bus.busy), 64'd0);
        end
        check("no_overflow_after_vectors", 64'(bus.overflow), 64'd0);

        // two extra requests while the sensor is busy: one queued, one dropped
        clear_stats();
        sens_delay = 20;
        sens_rc = 8'h44;
        sens_rv = 8'h55;
        sens_err = 1'b0;
        send_rx(8'h01, 8'h02);
        wait_starts("ovf_first_start", 1, 20);
        run(3);
        send_rx(8'h02, 8'h03);
        run(2);
        send_rx(8'h00, 8'h04);
        run(300);
        check("ovf_starts", 64'(n_start), 64'd2);
        check("ovf_second_addr", 64'(addr_log.size() > 1 ? addr_log[1] : 8'hFF), 64'h03);
        check("ovf_flag", 64'(bus.overflow), 64'd1);
        check("ovf_tx_count", 64'(n_tx), 64'd2);
        do_reset("ovf_reset_outputs");

        // continuous mode: three polls, then stop
        clear_stats();
        sens_delay = 10;
        sens_rc = 8'h12;
        sens_rv = 8'h34;
        send_rx(8'h03, 8'h02);
        wait_starts("poll_four_starts", 4, 5000);
        for (int i = 1; i < 4; i++) begin
            check_range($sformatf("poll_interval%0d", i),
                        start_log.size() > i ? start_log[i] - start_log[i-1] : 0, 990, 1010);
        end
        run(60);
        check("poll_tx_count", 64'(n_tx), 64'd4);
        check("poll_tx_bytes", 64'({tx_c, tx_v}), 64'h1234);
        check("poll_addr", 64'(st_addr), 64'h02);
        send_rx(8'h05, 8'h02);
        run(100);
        check("stop_tx_bytes", 64'({tx_c, tx_v}), 64'h0A00);
        check("stop_tx_count", 64'(n_tx), 64'd5);
        run(2500);
        check("stop_no_more_starts", 64'(n_start), 64'd4);

        // reset in WAIT_SENSOR with a continuous slot loaded
        clear_stats();
        sens_delay = 40;
        send_rx(8'h03, 8'h07);
        wait_starts("rst1_start", 1, 20);
        run(5);
        check("rst1_busy_before", 64'(bus.busy), 64'd1);
        check("rst1_addr_held", 64'(bus.sensor_address), 64'h07);
        do_reset("rst1_outputs");
        run(2500);
        check("rst1_slot_cleared", 64'(n_start), 64'd1);

        // reset in WAIT_TX_DONE with a continuous slot loaded
        clear_stats();
        sens_delay = 5;
        send_rx(8'h04, 8'h08);
        begin
            int k;
            k = 0;
            while (n_tx < 1 && k < 50) begin
                env_step();
                k++;
            end
        end
        check("rst2_tx_seen", 64'(n_tx), 64'd1);
        run(2);
        check("rst2_busy_before", 64'({bus.busy, bus.tx_busy}), 64'b11);
        do_reset("rst2_outputs");
        run(2500);
        check("rst2_slot_cleared", 64'(n_start), 64'd1);
        check("rst2_idle_end", 64'(bus.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
